// File: rtl/dma_port_arbiter_if.sv
// Bus bundle between the four request slots, the arbiter and the DMA controller port.
// master: requesters plus DMA controller side; slave: the arbiter itself.
interface dma_port_arbiter_if;
    // Requester side
    logic [3:0]   req_valid;
    logic [3:0]   req_read;
    logic [127:0] req_address;
    logic [15:0]  req_byteEnable;
    logic [127:0] req_writeData;
    logic [3:0]   req_busy;
    logic [3:0]   req_done;
    logic [3:0]   req_error;
    logic [31:0]  req_readData;

    // DMA controller side
    logic         s_dataReady;
    logic         s_readReady;
    logic [3:0]   s_byteEnable;
    logic [31:0]  s_address;
    logic [31:0]  s_writeData;
    logic         s_endTransaction;
    logic         s_dataValid;
    logic [31:0]  s_readData;

    modport master (
        output req_valid, req_read, req_address, req_byteEnable, req_writeData,
        input  req_busy, req_done, req_error, req_readData,
        input  s_dataReady, s_readReady, s_byteEnable, s_address, s_writeData,
        output s_endTransaction, s_dataValid, s_readData
    );

    modport slave (
        input  req_valid, req_read, req_address, req_byteEnable, req_writeData,
        output req_busy, req_done, req_error, req_readData,
        output s_dataReady, s_readReady, s_byteEnable, s_address, s_writeData,
        input  s_endTransaction, s_dataValid, s_readData
    );
endinterface

// File: rtl/dma_port_arbiter.sv
// dma_port_arbiter: four single-word request slots share one DMA controller transaction
// port. Round-robin grant, one transaction in flight, WAIT watchdog reports a timeout error.
module dma_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dma_port_arbiter_if.slave bus_io
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // Counter value of the last WAIT cycle allowed before the watchdog fires.
    localparam logic [15:0] LastWaitCnt = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_owner_q, last_owner_d;
    logic [3:0]  pending_q, pending_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    // Per-slot stored request, gathered into arrays for muxing by owner.
    logic [3:0]       slot_read;
    logic [3:0][31:0] slot_addr;
    logic [3:0][3:0]  slot_be;
    logic [3:0][31:0] slot_wdata;

    logic [3:0] busy;
    logic [3:0] accept;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic [3:0] grant_mask;

    // The owner stays busy from grant until its DONE cycle so it cannot overwrite live data.
    assign busy   = pending_q | ((state_q != StIdle) ? (4'b0001 << owner_q) : 4'b0000);
    assign accept = bus_io.req_valid & ~busy;

    for (genvar i = 0; i < 4; i++) begin : gen_slot
        logic        read_q;
        logic [31:0] addr_q;
        logic [3:0]  be_q;
        logic [31:0] wdata_q;

        // Capture a request only when the slot is free; busy pulses leave contents untouched.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                read_q  <= 1'b0;
                addr_q  <= '0;
                be_q    <= '0;
                wdata_q <= '0;
            end else if (accept[i]) begin
                read_q  <= bus_io.req_read[i];
                addr_q  <= bus_io.req_address[32*i +: 32];
                be_q    <= bus_io.req_byteEnable[4*i +: 4];
                wdata_q <= bus_io.req_writeData[32*i +: 32];
            end
        end

        assign slot_read[i]  = read_q;
        assign slot_addr[i]  = addr_q;
        assign slot_be[i]    = be_q;
        assign slot_wdata[i] = wdata_q;
    end

    // Round-robin search over registered pending bits, starting after the last owner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_owner_q + 2'(k);
            if (!grant_valid && pending_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_mask = (state_q == StIdle && grant_valid) ? (4'b0001 << grant_idx) : 4'b0000;

    // Pending bits: winner clears on grant, newly accepted requests set.
    always_comb begin
        pending_d = (pending_q & ~grant_mask) | accept;
    end

    // Transaction sequencing: grant, one-cycle issue, wait for completion or watchdog, report.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d = StIssue;
                    owner_d = grant_idx;
                    cnt_d   = '0;
                    rdata_d = '0;
                    error_d = 1'b0;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 16'd1;
                // Writes never return data, so a stray strobe cannot pollute req_readData.
                if (bus_io.s_dataValid && slot_read[owner_q]) begin
                    rdata_d = bus_io.s_readData;
                end
                // Completion takes precedence over a watchdog expiring in the same cycle.
                if (bus_io.s_endTransaction) begin
                    state_d = StDone;
                    error_d = 1'b0;
                end else if (cnt_q == LastWaitCnt) begin
                    state_d = StDone;
                    error_d = 1'b1;
                end
            end
            StDone: begin
                state_d      = StIdle;
                last_owner_d = owner_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Scheduler state; last_owner resets to 3 so slot 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd3;
            pending_q    <= 4'b0000;
            cnt_q        <= '0;
            rdata_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            error_q      <= error_d;
        end
    end

    // Outputs are decoded from state: DMA strobes only in ISSUE, completion only in DONE.
    always_comb begin
        bus_io.req_busy     = busy;
        bus_io.req_done     = 4'b0000;
        bus_io.req_error    = 4'b0000;
        bus_io.req_readData = '0;
        bus_io.s_dataReady  = 1'b0;
        bus_io.s_readReady  = 1'b0;
        bus_io.s_byteEnable = '0;
        bus_io.s_address    = '0;
        bus_io.s_writeData  = '0;
        if (state_q == StIssue) begin
            bus_io.s_readReady  = slot_read[owner_q];
            bus_io.s_dataReady  = ~slot_read[owner_q];
            bus_io.s_byteEnable = slot_be[owner_q];
            bus_io.s_address    = slot_addr[owner_q];
            bus_io.s_writeData  = slot_wdata[owner_q];
        end
        if (state_q == StDone) begin
            bus_io.req_done     = 4'b0001 << owner_q;
            bus_io.req_error    = {3'b000, error_q} << owner_q;
            bus_io.req_readData = rdata_q;
        end
    end

endmodule

// File: tb/tb_dma_port_arbiter.sv
// Scoreboard bench for dma_port_arbiter: a transaction-timeline model predicts every issue
// and completion; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dma_port_arbiter;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_port_arbiter_if bus ();

    dma_port_arbiter #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          slot;
        logic        rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          at;
    } iss_t;

    typedef struct {
        int          slot;
        logic        err;
        logic [31:0] data;
        int          at;
    } done_t;

    iss_t        iss_q[$];
    done_t       done_q[$];
    logic [31:0] obs_addr[$];

    // Model: slot contents, pending set and a timeline of the transaction in flight.
    bit          m_pend[4];
    int          m_since[4];
    logic        m_rd[4];
    logic [31:0] m_addr[4];
    logic [3:0]  m_be[4];
    logic [31:0] m_wd[4];
    int          m_owner = -1;
    int          m_done_at = -1;
    int          m_last = 3;
    int          m_free = 0;
    logic [3:0]  exp_busy = 4'b0000;

    // DMA response plan of the transaction in flight, indexed by WAIT cycle number.
    int          w_start = -1;
    int          w_last = -1;
    int          w_k = 0;
    logic [15:0] w_mask = '0;
    logic [31:0] w_data[16];

    bit          ov_on = 1'b0;
    int          ov_k = 0;
    logic [15:0] ov_mask = '0;
    logic [31:0] ov_data = '0;

    logic        nx_rd[4];
    logic [31:0] nx_addr[4];
    logic [3:0]  nx_be[4];
    logic [31:0] nx_wd[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_slot(input int i, input logic rd, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        nx_rd[i]   = rd;
        nx_addr[i] = a;
        nx_be[i]   = be;
        nx_wd[i]   = wd;
    endtask

    task automatic plan(input int k, input logic [15:0] mask, input logic [31:0] d);
        ov_on   = 1'b1;
        ov_k    = k;
        ov_mask = mask;
        ov_data = d;
    endtask

    // Grant a slot at cycle c: issue at c+1, WAIT from c+2, completion or watchdog decides DONE.
    task automatic start_txn(input int win, input int c);
        int          k;
        int          fin;
        logic        err;
        logic [31:0] rdv;
        k      = ov_on ? ov_k : int'($urandom_range(0, 11));
        w_mask = ov_on ? ov_mask : 16'($urandom);
        for (int j = 0; j < 16; j++) w_data[j] = ov_on ? ov_data : $urandom;
        ov_on = 1'b0;
        fin   = (k < int'(TO)) ? k : int'(TO) - 1;
        err   = (k >= int'(TO));
        rdv   = '0;
        if (m_rd[win]) begin
            for (int j = 0; j <= fin; j++) if (w_mask[j]) rdv = w_data[j];
        end
        iss_q.push_back('{win, m_rd[win], m_addr[win], m_be[win], m_wd[win], c + 1});
        done_q.push_back('{win, err, rdv, c + 3 + fin});
        m_pend[win] = 1'b0;
        m_owner     = win;
        m_done_at   = c + 3 + fin;
        m_free      = m_done_at + 1;
        m_last      = win;
        w_start     = c + 2;
        w_last      = c + 2 + fin;
        w_k         = k;
    endtask

    task automatic model_cycle(input int c, input logic [3:0] v);
        int win;
        if (m_owner >= 0 && c > m_done_at) m_owner = -1;
        if (m_owner < 0 && c >= m_free) begin
            win = -1;
            for (int s = 1; s <= 4; s++) begin
                int cd;
                cd = (m_last + s) % 4;
                if (win < 0 && m_pend[cd] && m_since[cd] <= c) win = cd;
            end
            if (win >= 0) start_txn(win, c);
        end
        for (int i = 0; i < 4; i++) exp_busy[i] = m_pend[i] || (m_owner == i);
        for (int i = 0; i < 4; i++) begin
            if (v[i] && !exp_busy[i]) begin
                m_pend[i]  = 1'b1;
                m_since[i] = c + 1;
                m_rd[i]    = nx_rd[i];
                m_addr[i]  = nx_addr[i];
                m_be[i]    = nx_be[i];
                m_wd[i]    = nx_wd[i];
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_owner  = -1;
        m_last   = 3;
        m_free   = 0;
        w_start  = -1;
        w_last   = -1;
        exp_busy = 4'b0000;
        iss_q.delete();
        done_q.delete();
    endtask

    // Inside the planned WAIT window follow the plan; elsewhere inject noise that must be ignored.
    task automatic drive_dma(input int c);
        int idx;
        if (w_start >= 0 && c >= w_start && c <= w_last) begin
            idx                  = c - w_start;
            bus.s_dataValid      = w_mask[idx];
            bus.s_readData       = w_data[idx];
            bus.s_endTransaction = (idx == w_k);
        end else begin
            bus.s_dataValid      = ($urandom_range(0, 3) == 0);
            bus.s_readData       = $urandom;
            bus.s_endTransaction = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic tick(input logic [3:0] v);
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        model_cycle(c, v);
        drive_dma(c);
        bus.req_valid = v;
        for (int i = 0; i < 4; i++) begin
            bus.req_read[i]                 = nx_rd[i];
            bus.req_address[32*i +: 32]     = nx_addr[i];
            bus.req_byteEnable[4*i +: 4]    = nx_be[i];
            bus.req_writeData[32*i +: 32]   = nx_wd[i];
        end
    endtask

    function automatic bit model_active();
        bit a;
        a = (m_owner >= 0);
        for (int i = 0; i < 4; i++) a = a | m_pend[i];
        return a;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (model_active() && n < 300) begin
            tick(4'b0000);
            n++;
        end
        if (n >= 300) check("drain_budget", 64'(n), 64'd0);
        tick(4'b0000);
    endtask

    // Monitor: compare every cycle; pop the scoreboard when the DUT issues or completes.
    always @(negedge clk) begin
        iss_t  ie;
        done_t de;
        check("busy", 64'(bus.req_busy), 64'(exp_busy));
        if (bus.s_readReady || bus.s_dataReady) begin
            obs_addr.push_back(bus.s_address);
            if (iss_q.size() == 0) begin
                check("unexpected_issue", 64'(bus.s_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ie = iss_q.pop_front();
                check("issue_cycle", 64'(cyc), 64'(ie.at));
                check("issue_strobes", 64'({bus.s_readReady, bus.s_dataReady}),
                      64'({ie.rd, ~ie.rd}));
                check("issue_addr", 64'(bus.s_address), 64'(ie.addr));
                check("issue_be", 64'(bus.s_byteEnable), 64'(ie.be));
                check("issue_wdata", 64'(bus.s_writeData), 64'(ie.wd));
            end
        end else begin
            check("s_idle_zero", 64'(|{bus.s_address, bus.s_byteEnable, bus.s_writeData}), 64'd0);
        end
        if (|bus.req_done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 64'(bus.req_done), 64'd0);
            end else begin
                de = done_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(de.at));
                check("done_vec", 64'(bus.req_done), 64'(4'b0001 << de.slot));
                check("done_error", 64'(bus.req_error), 64'({3'b000, de.err} << de.slot));
                check("done_rdata", 64'(bus.req_readData), 64'(de.data));
            end
        end else begin
            check("done_idle_zero", 64'(|{bus.req_error, bus.req_readData}), 64'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    int rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req_valid        = '0;
        bus.req_read         = '0;
        bus.req_address      = '0;
        bus.req_byteEnable   = '0;
        bus.req_writeData    = '0;
        bus.s_endTransaction = 1'b0;
        bus.s_dataValid      = 1'b0;
        bus.s_readData       = '0;
        for (int i = 0; i < 4; i++) set_slot(i, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin straight after reset, re-pulsing every slot each cycle.
        for (int i = 0; i < 4; i++)
            set_slot(i, 1'(i & 1), 32'hA000 + 32'h100 * i, 4'hF, 32'h5000 + i);
        obs_addr.delete();
        for (int n = 0; n < 200 && obs_addr.size() < 5; n++) tick(4'b1111);
        for (int j = 0; j < 5; j++)
            check("rr_order", 64'((j < obs_addr.size()) ? obs_addr[j] : 32'hFFFF_FFFF),
                  64'(32'hA000 + 32'h100 * rr[j]));
        drain();

        // Single read: data strobe in WAIT 1, completion 3 cycles after ISSUE.
        set_slot(2, 1'b1, 32'h0000_1000, 4'hF, 32'h0);
        plan(2, 16'h0002, 32'hDEAD_BEEF);
        tick(4'b0100);
        drain();

        // Write with partial byte enables; data strobes must not reach req_readData.
        set_slot(0, 1'b0, 32'h0000_2000, 4'b0011, 32'h1234_5678);
        plan(1, 16'hFFFF, 32'h7777_7777);
        tick(4'b0001);
        drain();

        // Watchdog timeout, then completion coinciding with the last allowed WAIT cycle.
        set_slot(1, 1'b1, 32'h0000_3000, 4'hF, 32'h0);
        plan(100, 16'h0000, 32'h0);
        tick(4'b0010);
        drain();
        set_slot(3, 1'b1, 32'h0000_3300, 4'hF, 32'h0);
        plan(int'(TO) - 1, 16'h0001, 32'hCAFE_F00D);
        tick(4'b1000);
        drain();

        // Busy rejection on slot 1, slot 3 queued during WAIT.
        set_slot(1, 1'b0, 32'h0000_0111, 4'hF, 32'h1111_0000);
        plan(4, 16'h0000, 32'h0);
        tick(4'b0010);
        set_slot(1, 1'b0, 32'h0000_0222, 4'hF, 32'h2222_0000);
        tick(4'b0010);
        tick(4'b0000);
        set_slot(1, 1'b0, 32'h0000_0333, 4'hF, 32'h3333_0000);
        set_slot(3, 1'b1, 32'h0000_0444, 4'h1, 32'h0);
        tick(4'b1010);
        drain();

        // Owner pulse in its DONE cycle is ignored; one cycle later it is accepted.
        set_slot(0, 1'b1, 32'h0000_00B0, 4'hF, 32'h0);
        plan(0, 16'h0001, 32'h0BB0_0BB0);
        tick(4'b0001);
        repeat (3) tick(4'b0000);
        set_slot(0, 1'b1, 32'h0000_00B1, 4'hF, 32'h0);
        tick(4'b0001);
        set_slot(0, 1'b0, 32'h0000_00B2, 4'h8, 32'hB2B2_B2B2);
        tick(4'b0001);
        drain();

        // Randomized traffic with random DMA latency, data strobes and noise.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++)
                set_slot(i, 1'($urandom), $urandom, 4'($urandom), $urandom);
            tick(4'($urandom) & 4'($urandom) & 4'($urandom));
        end
        drain();

        // Reset in the second WAIT cycle of slot 0 with slot 2 pending.
        set_slot(0, 1'b1, 32'h0000_C000, 4'hF, 32'h0);
        plan(100, 16'h0000, 32'h0);
        tick(4'b0001);
        set_slot(2, 1'b0, 32'h0000_C200, 4'hF, 32'hC2C2_C2C2);
        tick(4'b0100);
        tick(4'b0000);
        tick(4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        bus.req_valid        = '0;
        bus.s_endTransaction = 1'b0;
        bus.s_dataValid      = 1'b0;
        #1;
        check("rst_busy", 64'(bus.req_busy), 64'd0);
        check("rst_outputs", 64'(|{bus.req_done, bus.req_error, bus.req_readData,
                                    bus.s_dataReady, bus.s_readReady, bus.s_byteEnable,
                                    bus.s_address, bus.s_writeData}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_addr.delete();
        repeat (30) tick(4'b0000);
        check("no_issue_after_rst", 64'(obs_addr.size()), 64'd0);

        drain();
        check("issue_queue_empty", 64'(iss_q.size()), 64'd0);
        check("done_queue_empty", 64'(done_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_port_arbiter.md
# dma_port_arbiter

Shares the single transaction port of the JTAG-side DMA controller between four requesters: CPU custom-instruction front ends, the JTAG command path and a debug/test master. Each requester posts one single-word read or write into its own request slot. A round-robin scheduler issues the slots one at a time to the DMA controller, waits for completion or a watchdog timeout, and returns a completion pulse, read data and error status to the owner.

## Interface
- TIMEOUT_CYCLES, default 1024: maximum number of WAIT cycles before a transaction is aborted. Legal range is 2..65535.
- clock  in  1  single system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  4  one-cycle request pulse, one bit per requester.
- req_read  in  4  per requester: 1 = read, 0 = write.
- req_address  in  128  per requester, 32 bits each; requester i uses [32i+31:32i].
- req_byteEnable  in  16  per requester, 4 bits each.
- req_writeData  in  128  per requester, 32 bits each.
- req_busy  out  4  slot i is pending or in service.
- req_done  out  4  one-cycle completion pulse to the owner.
- req_error  out  4  qualified by req_done; 1 = timeout.
- req_readData  out  32  read result; valid only while req_done is high.
- s_dataReady  out  1  write strobe to the DMA controller.
- s_readReady  out  1  read strobe to the DMA controller.
- s_byteEnable  out  4  byte enables of the issued transaction.
- s_address  out  32  address of the issued transaction.
- s_writeData  out  32  write data of the issued transaction.
- s_endTransaction  in  1  DMA controller has finished the transaction.
- s_dataValid  in  1  s_readData is valid this cycle.
- s_readData  in  32  read data from the DMA controller.

## Operation
- Slots:
  - When req_valid[i]=1 and req_busy[i]=0, slot i captures read, address, byteEnable and writeData and sets pending[i].
  - When req_valid[i]=1 and req_busy[i]=1, the pulse is ignored and the slot contents are unchanged.
  - req_busy[i] = pending[i] OR (owner==i and state != IDLE).
- Arbitration:
  - Performed in IDLE, over registered pending bits only.
  - Priority order starts at last_owner+1 and wraps modulo 4.
  - last_owner resets to 3, so requester 0 has top priority after reset.
  - The winner's pending bit clears when it is granted; the slot data is held until DONE.
- FSM, with states IDLE, ISSUE, WAIT, DONE:
  - IDLE -> ISSUE when any pending bit is set. On that edge the scheduler latches owner and clears the timeout counter and the read-data register.
  - ISSUE -> WAIT unconditionally. In ISSUE:
    - s_readReady = read, s_dataReady = ~read.
    - s_address, s_byteEnable and s_writeData carry the owner slot contents.
  - WAIT, on s_dataValid: capture s_readData.
  - WAIT -> DONE on s_endTransaction, with error=0.
  - WAIT -> DONE with error=1 when the counter reaches TIMEOUT_CYCLES-1 without s_endTransaction.
  - DONE -> IDLE. In DONE:
    - req_done[owner]=1 and req_error[owner]=error.
    - req_readData = captured data; this is 0 for writes and for reads that received no s_dataValid.
    - last_owner <= owner.
- Outside ISSUE, all s_* outputs are 0. Outside DONE, req_done, req_error and req_readData are 0.

## Timing
- Reset values:
  - All outputs are 0.
  - pending = 0, state = IDLE, last_owner = 3, counter = 0.
- Latency:
  - A request pulse in cycle T on an idle arbiter gives pending in T+1, ISSUE in T+2 and WAIT in T+3.
  - s_endTransaction in WAIT cycle W gives DONE in W+1.
  - The next grant reaches ISSUE no earlier than 2 cycles after DONE.
- The timeout counter increments on every WAIT cycle.
- s_endTransaction and s_dataValid are ignored outside WAIT.
- s_dataValid and s_endTransaction in the same WAIT cycle: data is captured and the transaction completes with no error.
- s_endTransaction in the same cycle the timeout would fire: completion wins and error=0.
- Multiple s_dataValid pulses: the last one wins.
- A req_valid pulse from the owner in its DONE cycle is ignored (req_busy is still 1). A pulse one cycle later is accepted.
- A req_valid pulse for a non-owner slot during ISSUE, WAIT or DONE is accepted and queues normally.
- Reset asserted mid-transaction: everything returns to reset values immediately. The in-flight transaction and all pending requests are discarded and no req_done is produced.

## Test plan
- Single read:
  - Stimulus: req_valid[2] pulse, read=1, address 0x0000_1000; DMA returns 0xDEAD_BEEF with s_dataValid, then s_endTransaction 3 cycles after ISSUE.
  - Required: s_readReady=1 and s_address=0x0000_1000 for exactly one cycle; req_done[2]=1 with req_readData=0xDEAD_BEEF and req_error[2]=0.
- Write:
  - Stimulus: req_valid[0] pulse, read=0, byteEnable 4'b0011, data 0x1234_5678.
  - Required: during ISSUE, s_dataReady=1, s_byteEnable=4'b0011, s_writeData=0x1234_5678; at DONE, req_readData=0.
- Round-robin:
  - Stimulus: all four slots pulsed in the same cycle straight after reset, and again as each completes.
  - Required: service order 0,1,2,3,0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, s_endTransaction never asserted.
  - Required: DONE after exactly 8 WAIT cycles with req_error[owner]=1 and req_readData=0.
- Busy rejection and queueing:
  - Stimulus: second pulse on slot 1 while it is busy, with a different address; slot 3 pulsed during WAIT.
  - Required: slot 1 issues only its original address; slot 3 is issued next.
- Reset mid-WAIT:
  - Stimulus: reset asserted in the second WAIT cycle with slot 2 pending.
  - Required: all outputs 0 immediately, no req_done, and slot 2 is never issued after reset deasserts.
